acq_scheduler: RTL and testbench

Sequences the acquisition correlator engine through a full satellite search: for each enabled PRN (1..32) it sweeps every Doppler bin, issues one correlation per bin, and keeps the strongest peak. After the sweep, each PRN's best peak is compared against a threshold. Detected PRNs are reported as a bitmask plus a per-PRN result record (Doppler bin, code phase). The block sits between the top-level control and the acquisition datapath, and owns that datapath exclusively.

---
 rtl/acq_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_acq_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_scheduler.sv
// Acquisition scheduler: sweeps PRNs x Doppler bins through the correlator
// engine, keeps the strongest peak per PRN and reports detections.
module acq_scheduler #(
    parameter int unsigned DOPP_MAX  = 5000,
    parameter int unsigned DOPP_STEP = 500,
    parameter int unsigned PEAK_W    = 32,
    parameter int unsigned PHASE_W   = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [31:0]        sat_mask_i,
    input  logic [PEAK_W-1:0]  threshold_i,
    output logic               eng_start_o,
    output logic [4:0]         eng_prn_o,
    output logic [15:0]        eng_doppler_o,
    input  logic               eng_done_i,
    input  logic [PEAK_W-1:0]  eng_peak_i,
    input  logic [PHASE_W-1:0] eng_phase_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [31:0]        detectedSAT,
    output logic               res_valid_o,
    output logic [4:0]         res_prn_o,
    output logic [15:0]        res_doppler_o,
    output logic [PHASE_W-1:0] res_phase_o
);

    localparam int unsigned DOPP_W = 16;
    localparam int unsigned PRN_W  = 5;

    localparam logic signed [DOPP_W-1:0] DMAX  = DOPP_W'(DOPP_MAX);
    localparam logic signed [DOPP_W-1:0] DSTEP = DOPP_W'(DOPP_STEP);
    localparam logic signed [DOPP_W-1:0] DMIN  = -DMAX;
    localparam logic [PRN_W-1:0]         PRN_LAST = PRN_W'(31);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        NEXT_BIN,
        DECIDE,
        NEXT_PRN,
        FINISH
    } state_e;

    state_e                    state_q, state_d;
    logic [31:0]               mask_q, mask_d;
    logic [PEAK_W-1:0]         thr_q, thr_d;
    logic [31:0]               acc_q, acc_d;
    logic [PRN_W-1:0]          prn_q, prn_d;
    logic signed [DOPP_W-1:0]  dopp_q, dopp_d;
    logic [PEAK_W-1:0]         best_peak_q, best_peak_d;
    logic signed [DOPP_W-1:0]  best_dopp_q, best_dopp_d;
    logic [PHASE_W-1:0]        best_phase_q, best_phase_d;

    logic                      eng_start_q, eng_start_d;
    logic [PRN_W-1:0]          eng_prn_q, eng_prn_d;
    logic signed [DOPP_W-1:0]  eng_dopp_q, eng_dopp_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [31:0]               det_q, det_d;
    logic                      res_valid_q, res_valid_d;
    logic [PRN_W-1:0]          res_prn_q, res_prn_d;
    logic signed [DOPP_W-1:0]  res_dopp_q, res_dopp_d;
    logic [PHASE_W-1:0]        res_phase_q, res_phase_d;

    // Next-state and registered-output computation for the search sequence.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        thr_d        = thr_q;
        acc_d        = acc_q;
        prn_d        = prn_q;
        dopp_d       = dopp_q;
        best_peak_d  = best_peak_q;
        best_dopp_d  = best_dopp_q;
        best_phase_d = best_phase_q;
        eng_start_d  = 1'b0;
        eng_prn_d    = eng_prn_q;
        eng_dopp_d   = eng_dopp_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        det_d        = det_q;
        res_valid_d  = 1'b0;
        res_prn_d    = res_prn_q;
        res_dopp_d   = res_dopp_q;
        res_phase_d  = res_phase_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mask_d  = sat_mask_i;
                    thr_d   = threshold_i;
                    acc_d   = '0;
                    prn_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!mask_q[prn_q]) begin
                    state_d = NEXT_PRN;
                end else begin
                    dopp_d       = DMIN;
                    best_peak_d  = '0;
                    best_dopp_d  = DMIN;
                    best_phase_d = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                eng_start_d = 1'b1;
                eng_prn_d   = prn_q;
                eng_dopp_d  = dopp_q;
                state_d     = WAIT;
            end
            WAIT: begin
                if (eng_done_i) begin
                    // Strict compare: on ties the earlier (lower) bin wins.
                    if (eng_peak_i > best_peak_q) begin
                        best_peak_d  = eng_peak_i;
                        best_dopp_d  = dopp_q;
                        best_phase_d = eng_phase_i;
                    end
                    state_d = NEXT_BIN;
                end
            end
            NEXT_BIN: begin
                if (dopp_q == DMAX) begin
                    state_d = DECIDE;
                end else begin
                    dopp_d  = dopp_q + DSTEP;
                    state_d = ISSUE;
                end
            end
            DECIDE: begin
                if (best_peak_q >= thr_q) begin
                    acc_d[prn_q] = 1'b1;
                    res_valid_d  = 1'b1;
                    res_prn_d    = prn_q;
                    res_dopp_d   = best_dopp_q;
                    res_phase_d  = best_phase_q;
                end
                state_d = NEXT_PRN;
            end
            NEXT_PRN: begin
                if (prn_q == PRN_LAST) begin
                    state_d = FINISH;
                end else begin
                    prn_d   = prn_q + PRN_W'(1);
                    state_d = SCAN;
                end
            end
            FINISH: begin
                det_d   = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any search in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            thr_q        <= '0;
            acc_q        <= '0;
            prn_q        <= '0;
            dopp_q       <= '0;
            best_peak_q  <= '0;
            best_dopp_q  <= '0;
            best_phase_q <= '0;
            eng_start_q  <= 1'b0;
            eng_prn_q    <= '0;
            eng_dopp_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            det_q        <= '0;
            res_valid_q  <= 1'b0;
            res_prn_q    <= '0;
            res_dopp_q   <= '0;
            res_phase_q  <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            thr_q        <= thr_d;
            acc_q        <= acc_d;
            prn_q        <= prn_d;
            dopp_q       <= dopp_d;
            best_peak_q  <= best_peak_d;
            best_dopp_q  <= best_dopp_d;
            best_phase_q <= best_phase_d;
            eng_start_q  <= eng_start_d;
            eng_prn_q    <= eng_prn_d;
            eng_dopp_q   <= eng_dopp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            det_q        <= det_d;
            res_valid_q  <= res_valid_d;
            res_prn_q    <= res_prn_d;
            res_dopp_q   <= res_dopp_d;
            res_phase_q  <= res_phase_d;
        end
    end

    assign eng_start_o   = eng_start_q;
    assign eng_prn_o     = eng_prn_q;
    assign eng_doppler_o = eng_dopp_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign detectedSAT   = det_q;
    assign res_valid_o   = res_valid_q;
    assign res_prn_o     = res_prn_q;
    assign res_doppler_o = res_dopp_q;
    assign res_phase_o   = res_phase_q;

endmodule

// File: tb/tb_acq_scheduler.sv
// Bench for acq_scheduler: engine responder plus job/result scoreboards.
module tb_acq_scheduler;

    localparam int DMAX  = 5000;
    localparam int DSTEP = 500;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [31:0] sat_mask_i;
    logic [31:0] threshold_i;
    logic        eng_start_o;
    logic [4:0]  eng_prn_o;
    logic [15:0] eng_doppler_o;
    logic        eng_done_i;
    logic [31:0] eng_peak_i;
    logic [10:0] eng_phase_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] detectedSAT;
    logic        res_valid_o;
    logic [4:0]  res_prn_o;
    logic [15:0] res_doppler_o;
    logic [10:0] res_phase_o;

    acq_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .sat_mask_i   (sat_mask_i),
        .threshold_i  (threshold_i),
        .eng_start_o  (eng_start_o),
        .eng_prn_o    (eng_prn_o),
        .eng_doppler_o(eng_doppler_o),
        .eng_done_i   (eng_done_i),
        .eng_peak_i   (eng_peak_i),
        .eng_phase_i  (eng_phase_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .detectedSAT  (detectedSAT),
        .res_valid_o  (res_valid_o),
        .res_prn_o    (res_prn_o),
        .res_doppler_o(res_doppler_o),
        .res_phase_o  (res_phase_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Engine model configuration (strong bins on one PRN, 100 elsewhere)
    int          hit_prn  = -1;
    int          hit_d1   = 0;
    int          hit_d2   = 0;
    logic [31:0] hit_peak = 0;
    logic [10:0] hit_ph1  = 0;
    logic [10:0] hit_ph2  = 0;
    int          eng_lat  = 1;
    bit          spur_en  = 0;

    logic [31:0] last_det = 0;

    typedef struct { int prn; int dopp; } job_t;
    typedef struct { int prn; int dopp; int phase; } res_t;
    job_t job_q[$];
    res_t res_q[$];

    function automatic logic [31:0] model_peak(int prn, int dopp);
        if (prn == hit_prn && (dopp == hit_d1 || dopp == hit_d2)) return hit_peak;
        return 32'd100;
    endfunction

    function automatic logic [10:0] model_phase(int prn, int dopp);
        if (prn == hit_prn && dopp == hit_d1) return hit_ph1;
        if (prn == hit_prn && dopp == hit_d2) return hit_ph2;
        return 11'((dopp + DMAX) / DSTEP * 7 + prn);
    endfunction

    // Correlator engine responder; optional spurious done one cycle after each real one
    initial begin
        int cnt;
        int jp;
        int jd;
        bit spur;
        cnt = 0; jp = 0; jd = 0; spur = 0;
        eng_done_i  = 1'b0;
        eng_peak_i  = '0;
        eng_phase_i = '0;
        forever begin
            @(negedge clk);
            eng_done_i = 1'b0;
            if (!reset) begin
                cnt  = 0;
                spur = 0;
            end else if (spur) begin
                eng_done_i  = 1'b1;
                eng_peak_i  = '1;
                eng_phase_i = '1;
                spur        = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done_i  = 1'b1;
                    eng_peak_i  = model_peak(jp, jd);
                    eng_phase_i = model_phase(jp, jd);
                    spur        = spur_en;
                end
            end else if (eng_start_o) begin
                jp  = int'(eng_prn_o);
                jd  = int'($signed(eng_doppler_o));
                cnt = eng_lat;
            end
        end
    end

    // Runs one search and checks the job stream, results, busy, done and detectedSAT.
    task automatic do_search(input logic [31:0] mask, input logic [31:0] thr,
                             input bit disturb, output int jobs, output int cyc);
        logic [31:0] best;
        logic [31:0] pk;
        logic [31:0] exp_det;
        int          bd;
        int          bph;
        int          busy_gap;
        int          det_bad;
        bit          seen_done;
        job_t        j;
        res_t        r;
        job_q.delete();
        res_q.delete();
        exp_det = '0;
        for (int p = 0; p < 32; p++) begin
            if (mask[p]) begin
                best = 0; bd = -DMAX; bph = 0;
                for (int d = -DMAX; d <= DMAX; d += DSTEP) begin
                    job_q.push_back('{prn: p, dopp: d});
                    pk = model_peak(p, d);
                    if (pk > best) begin
                        best = pk; bd = d; bph = int'(model_phase(p, d));
                    end
                end
                if (best >= thr) begin
                    res_q.push_back('{prn: p, dopp: bd, phase: bph});
                    exp_det[p] = 1'b1;
                end
            end
        end

        jobs = 0; busy_gap = 0; det_bad = 0; seen_done = 0;
        @(negedge clk);
        sat_mask_i  = mask;
        threshold_i = thr;
        start_i     = 1'b1;
        for (cyc = 1; cyc <= 10000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_i     = 1'b0;
                sat_mask_i  = ~mask;
                threshold_i = '0;
            end
            if (disturb && cyc == 40) begin
                start_i = 1'b1; sat_mask_i = '1;
            end
            if (disturb && cyc == 41) start_i = 1'b0;
            if (eng_start_o) begin
                jobs++;
                total++;
                if (job_q.size() == 0) begin
                    bad++;
                    $display("FAIL job_extra: got prn=%0d dopp=%0d want none",
                             eng_prn_o, $signed(eng_doppler_o));
                end else begin
                    j = job_q.pop_front();
                    if (eng_prn_o !== 5'(j.prn) || eng_doppler_o !== 16'(j.dopp)) begin
                        bad++;
                        $display("FAIL job: got prn=%0d dopp=%0d want prn=%0d dopp=%0d",
                                 eng_prn_o, $signed(eng_doppler_o), j.prn, j.dopp);
                    end
                end
            end
            if (res_valid_o) begin
                total++;
                if (res_q.size() == 0) begin
                    bad++;
                    $display("FAIL res_extra: got prn=%0d want none", res_prn_o);
                end else begin
                    r = res_q.pop_front();
                    if (res_prn_o !== 5'(r.prn) || res_doppler_o !== 16'(r.dopp) ||
                        res_phase_o !== 11'(r.phase)) begin
                        bad++;
                        $display("FAIL res: got prn=%0d dopp=%0d ph=%0d want prn=%0d dopp=%0d ph=%0d",
                                 res_prn_o, $signed(res_doppler_o), res_phase_o,
                                 r.prn, r.dopp, r.phase);
                    end
                end
            end
            if (done_o) begin
                seen_done = 1;
                break;
            end
            if (busy_o !== 1'b1) busy_gap++;
            if (detectedSAT !== last_det) det_bad++;
        end

        total++;
        if (!seen_done) begin
            bad++;
            $display("FAIL done_timeout: got no done_o want done_o within 10000 cycles");
        end
        total++;
        if (busy_gap !== 0) begin
            bad++; $display("FAIL busy_during: got %0d low cycles want 0", busy_gap);
        end
        total++;
        if (det_bad !== 0) begin
            bad++; $display("FAIL det_hold: got %0d changed cycles want 0", det_bad);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL busy_at_done: got %0b want 0", busy_o);
        end
        total++;
        if (detectedSAT !== exp_det) begin
            bad++; $display("FAIL detected: got %08h want %08h", detectedSAT, exp_det);
        end
        total++;
        if (job_q.size() != 0 || res_q.size() != 0) begin
            bad++;
            $display("FAIL missing: got jobs_left=%0d res_left=%0d want 0 0",
                     job_q.size(), res_q.size());
        end
        @(negedge clk);
        total++;
        if (done_o !== 1'b0 || eng_start_o !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%0b eng_start=%0b want 0 0", done_o, eng_start_o);
        end
        last_det = exp_det;
    endtask

    task automatic test_reset();
        int bad_cmd;
        reset = 1'b0; start_i = 1'b1; sat_mask_i = '1; threshold_i = '0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({eng_start_o, eng_prn_o, eng_doppler_o, busy_o, done_o, detectedSAT,
                 res_valid_o, res_prn_o, res_doppler_o, res_phase_o} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got eng_start=%0b busy=%0b det=%08h want all 0",
                         eng_start_o, busy_o, detectedSAT);
            end
        end
        start_i = 1'b0;
        reset   = 1'b1;
        bad_cmd = 0;
        repeat (10) begin
            @(negedge clk);
            if (eng_start_o || busy_o || done_o) bad_cmd++;
        end
        total++;
        if (bad_cmd !== 0) begin
            bad++; $display("FAIL reset_idle: got %0d active cycles want 0", bad_cmd);
        end
        last_det = '0;
    endtask

    task automatic test_empty();
        int jobs;
        int cyc;
        do_search(32'h0, 32'd0, 0, jobs, cyc);
        total++;
        if (jobs !== 0) begin
            bad++; $display("FAIL empty_jobs: got %0d want 0", jobs);
        end
        // Start cycle is the first of the 67; done_o shows on the 67th.
        total++;
        if (cyc !== 66) begin
            bad++; $display("FAIL empty_latency: got %0d want 66", cyc);
        end
    endtask

    task automatic test_single();
        int jobs;
        int cyc;
        hit_prn = 2; hit_d1 = 1500; hit_d2 = 1500; hit_peak = 2000;
        hit_ph1 = 11'd377; hit_ph2 = 11'd377;
        do_search(32'h0000_0004, 32'd1000, 0, jobs, cyc);
        total++;
        if (jobs !== 21) begin
            bad++; $display("FAIL single_jobs: got %0d want 21", jobs);
        end
    endtask

    task automatic test_threshold();
        int jobs;
        int cyc;
        eng_lat = 3;
        do_search(32'h0000_0004, 32'd2000, 0, jobs, cyc);
        do_search(32'h0000_0004, 32'd2001, 0, jobs, cyc);
        total++;
        if (detectedSAT !== 32'h0) begin
            bad++; $display("FAIL thr_plus1: got %08h want 00000000", detectedSAT);
        end
        eng_lat = 1;
    endtask

    task automatic test_tie_full();
        int jobs;
        int cyc;
        hit_prn = 30; hit_d1 = -2000; hit_d2 = 3000; hit_peak = 5000;
        hit_ph1 = 11'd111; hit_ph2 = 11'd222;
        do_search(32'hFFFF_FFFF, 32'd1000, 0, jobs, cyc);
        total++;
        if (jobs !== 672) begin
            bad++; $display("FAIL full_jobs: got %0d want 672", jobs);
        end
        total++;
        if (detectedSAT !== 32'h4000_0000) begin
            bad++; $display("FAIL full_det: got %08h want 40000000", detectedSAT);
        end
    endtask

    task automatic test_robust();
        int jobs;
        int cyc;
        hit_prn = 2; hit_d1 = 1500; hit_d2 = 1500; hit_peak = 2000;
        hit_ph1 = 11'd377; hit_ph2 = 11'd377;
        spur_en = 1; eng_lat = 2;
        do_search(32'h0000_0004, 32'd1000, 1, jobs, cyc);
        total++;
        if (jobs !== 21) begin
            bad++; $display("FAIL robust_jobs: got %0d want 21", jobs);
        end
        spur_en = 0; eng_lat = 1;
    endtask

    task automatic test_abort();
        bit seen;
        int bad_cmd;
        eng_lat = 30;
        @(negedge clk);
        sat_mask_i = 32'h1; threshold_i = '0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (eng_start_o) seen = 1;
        end
        total++;
        if (seen !== 1'b1) begin
            bad++; $display("FAIL abort_issue: got no eng_start_o want one");
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({eng_start_o, eng_prn_o, eng_doppler_o, busy_o, done_o, detectedSAT,
             res_valid_o, res_prn_o, res_doppler_o, res_phase_o} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%0b det=%08h prn=%0d want all 0",
                     busy_o, detectedSAT, eng_prn_o);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        last_det = '0;
        bad_cmd = 0;
        repeat (60) begin
            @(negedge clk);
            if (eng_start_o || busy_o || done_o || res_valid_o) bad_cmd++;
        end
        total++;
        if (bad_cmd !== 0) begin
            bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad_cmd);
        end
        eng_lat = 1;
    endtask

    initial begin
        reset = 1'b0; start_i = 1'b0; sat_mask_i = '0; threshold_i = '0;
        test_reset();
        test_empty();
        test_single();
        test_threshold();
        test_tie_full();
        test_robust();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
